// File: rtl/exp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : exp_pkg
//  Purpose  : Shared widths, 1/n! coefficients and state encoding for the
//             fixed-point exponential engine.
//  Revision : 1.0  initial release
// ============================================================================
package exp_pkg;

    localparam int XW = 16;
    localparam int AW = XW + 2;
    localparam int PW = 17;

    localparam logic [PW-1:0] ONE   = 17'h10000;

    // Truncated 1/n! in Q1.16
    localparam logic [PW-1:0] COEF1 = 17'h10000;
    localparam logic [PW-1:0] COEF2 = 17'h08000;
    localparam logic [PW-1:0] COEF3 = 17'h02AAA;
    localparam logic [PW-1:0] COEF4 = 17'h00AAA;
    localparam logic [PW-1:0] COEF5 = 17'h00222;
    localparam logic [PW-1:0] COEF6 = 17'h0005B;
    localparam logic [PW-1:0] COEF7 = 17'h0000D;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULP = 2'd1;
    localparam logic [1:0] MULC = 2'd2;

endpackage
`default_nettype wire

// File: rtl/exp_coef_rom.sv
`default_nettype none
// ============================================================================
//  Module   : exp_coef_rom
//  Purpose  : Combinational 1/n! lookup; indices outside 1..7 return zero.
//  Revision : 1.0  initial release
// ============================================================================
module exp_coef_rom
    import exp_pkg::*;
(
    input  logic [2:0]    n,
    output logic [PW-1:0] coef
);

    always_comb begin
        coef = '0;
        case (n)
            3'd1:    coef = COEF1;
            3'd2:    coef = COEF2;
            3'd3:    coef = COEF3;
            3'd4:    coef = COEF4;
            3'd5:    coef = COEF5;
            3'd6:    coef = COEF6;
            3'd7:    coef = COEF7;
            default: coef = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/exp_engine.sv
`default_nettype none
// ============================================================================
//  Module   : exp_engine
//  Purpose  : e^x for x in [0,1) via truncated Taylor series on one shared
//             17x17 multiplier; engStart/engDone responder.
//  Revision : 1.0  initial release
// ============================================================================
module exp_engine #(
    parameter int XW   = exp_pkg::XW,
    parameter int ITER = 7,
    parameter int AW   = exp_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          engStart,
    input  logic [XW-1:0] xIn,
    output logic          engDone,
    output logic [AW-1:0] result,
    output logic          busy
);

    import exp_pkg::*;

    localparam int HW = 2*PW - XW;

    logic [1:0]    r_state;
    logic [XW-1:0] r_x;
    logic [PW-1:0] r_pw;
    logic [AW-1:0] r_acc;
    logic [2:0]    r_n;
    logic [AW-1:0] r_result;
    logic          r_done;
    logic          r_busy;

    logic [PW-1:0] w_coef;
    logic [PW-1:0] w_mul_a;
    logic [PW-1:0] w_mul_b;
    logic [HW-1:0] w_prod_hi;
    logic [AW-1:0] w_acc_next;

    exp_coef_rom u_rom (
        .n    (r_n),
        .coef (w_coef)
    );

    // One multiplier: MULP forms x^n, MULC scales it by 1/n!
    assign w_mul_a    = r_pw;
    assign w_mul_b    = (r_state == MULC) ? w_coef : PW'(r_x);
    assign w_prod_hi  = HW'(((2*PW)'(w_mul_a) * (2*PW)'(w_mul_b)) >> XW);
    assign w_acc_next = r_acc + AW'(w_prod_hi);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_x      <= '0;
            r_pw     <= '0;
            r_acc    <= '0;
            r_n      <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (engStart) begin
                        r_x     <= xIn;
                        r_pw    <= ONE;
                        r_acc   <= AW'(ONE);
                        r_n     <= 3'd1;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= MULP;
                    end
                end
                MULP: begin
                    r_pw    <= w_prod_hi[PW-1:0];
                    r_state <= MULC;
                end
                MULC: begin
                    r_acc <= w_acc_next;
                    if (r_n == 3'(ITER)) begin
                        r_result <= w_acc_next;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        r_n     <= r_n + 3'd1;
                        r_state <= MULP;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign engDone = r_done;
    assign result  = r_result;
    assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_exp_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exp_engine
//  Purpose  : Directed vectors and corner sequences for exp_engine.
//  Revision : 1.0  initial release
// ============================================================================
module tb_exp_engine;

    logic        clk;
    logic        rst;
    logic        engStart;
    logic [15:0] xIn;
    logic        engDone;
    logic [17:0] result;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] x;
        logic [17:0] expv;
        string       name;
    } vec_t;

    exp_engine #(.XW(16), .ITER(7), .AW(18)) dut (
        .clk      (clk),
        .rst      (rst),
        .engStart (engStart),
        .xIn      (xIn),
        .engDone  (engDone),
        .result   (result),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Independent truncating series reference
    function automatic logic [17:0] ref_exp(input logic [15:0] x);
        logic [16:0] c [1:7];
        logic [16:0] pw;
        logic [17:0] acc;
        logic [33:0] p;
        c[1] = 17'h10000; c[2] = 17'h08000; c[3] = 17'h02AAA; c[4] = 17'h00AAA;
        c[5] = 17'h00222; c[6] = 17'h0005B; c[7] = 17'h0000D;
        pw  = 17'h10000;
        acc = 18'h10000;
        for (int k = 1; k <= 7; k++) begin
            p   = {17'b0, pw} * {18'b0, x};
            pw  = p[32:16];
            p   = {17'b0, pw} * {17'b0, c[k]};
            acc = acc + {1'b0, p[32:16]};
        end
        return acc;
    endfunction

    // Start one operand, optionally pulse engStart at cycles 3 and 8, then
    // check latency, busy profile and result.
    task automatic run_op(input logic [15:0] x, input logic [17:0] expv,
                          input bit glitch, input string name);
        int cnt;
        int busy_low;
        bit seen;
        @(negedge clk);
        engStart = 1'b1;
        xIn      = x;
        @(negedge clk);
        engStart = 1'b0;
        xIn      = 16'h1234;
        check({name, "_done_low_at_accept"}, {31'b0, engDone}, 32'd0);
        check({name, "_busy_at_accept"}, {31'b0, busy}, 32'd1);
        cnt      = 0;
        busy_low = 0;
        seen     = 1'b0;
        while (cnt < 40 && !seen) begin
            if (glitch && (cnt == 3 || cnt == 8)) begin
                engStart = 1'b1;
                xIn      = 16'hFFFF;
            end
            @(negedge clk);
            engStart = 1'b0;
            cnt++;
            if (engDone) seen = 1'b1;
            else if (!busy) busy_low++;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: engDone not seen within 40 cycles", name);
        end else begin
            check({name, "_latency"}, cnt, 32'd14);
            check({name, "_result"}, {14'b0, result}, {14'b0, expv});
            check({name, "_busy_after"}, {31'b0, busy}, 32'd0);
        end
        check({name, "_busy_gaps"}, busy_low, 32'd0);
    endtask

    initial begin
        vec_t tbl [5];
        int   seen;
        tbl[0] = '{16'h0000, 18'h10000, "x0"};
        tbl[1] = '{16'h8000, 18'h1A611, "xhalf"};
        tbl[2] = '{16'h4000, 18'h148B4, "xquarter"};
        tbl[3] = '{16'h0001, 18'h10001, "xlsb"};
        tbl[4] = '{16'hFFFF, ref_exp(16'hFFFF), "xmax"};

        rst      = 1'b1;
        engStart = 1'b0;
        xIn      = '0;
        repeat (3) @(negedge clk);
        check("rst_done",   {31'b0, engDone}, 32'd0);
        check("rst_busy",   {31'b0, busy}, 32'd0);
        check("rst_result", {14'b0, result}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            run_op(tbl[i].x, tbl[i].expv, 1'b0, tbl[i].name);
        check("xmax_range", {31'b0, (result >= 18'h2B700 && result <= 18'h2B7E1)}, 32'd1);

        // Mid-run start pulses must be ignored
        run_op(16'h8000, 18'h1A611, 1'b1, "ignore");

        // Done and result held across idle cycles
        repeat (4) @(negedge clk);
        check("hold_done",   {31'b0, engDone}, 32'd1);
        check("hold_result", {14'b0, result}, 32'h1A611);

        // Restart while engDone is high
        run_op(16'h0000, 18'h10000, 1'b0, "b2b");

        // Reset during cycle 6 of a run
        @(negedge clk);
        engStart = 1'b1;
        xIn      = 16'h8000;
        @(negedge clk);
        engStart = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_done",   {31'b0, engDone}, 32'd0);
        check("abort_result", {14'b0, result}, 32'd0);
        check("abort_busy",   {31'b0, busy}, 32'd0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (engDone) seen = 1;
        end
        check("abort_no_done", seen, 32'd0);
        run_op(16'h4000, 18'h148B4, 1'b0, "after_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
